serial_clock: RTL and testbench

SERIAL_CLOCK -- requirements
Module: serial_clock

---
 rtl/serial_clock.sv | 80 ++++++++
 tb/tb_serial_clock.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_clock.sv
// serial_clock: divides clk into a 50%-duty serial clock (sclk) and produces
// one-clk strobes for sclk rising/falling edges and for every 8th rising edge,
// together with a 3-bit count of rising edges.
module serial_clock #(
  parameter int HALF_PERIOD = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       sclk,
  output logic       sclkPosEdge,
  output logic       sclkNegEdge,
  output logic       sclk8PosEdge,
  output logic [2:0] bitCount
);

  // Divide counter only needs to reach HALF_PERIOD-1; keep at least one bit.
  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          pos_q, pos_d;
  logic          neg_q, neg_d;
  logic          byte_q, byte_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          toggle;

  // Next-state: count half-period, flip sclk at terminal count, and derive
  // strobes from the direction of the flip so they line up with new sclk.
  always_comb begin
    toggle    = enable && (cnt_q == CNT_LAST);
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    bit_cnt_d = bit_cnt_q;
    pos_d     = 1'b0;
    neg_d     = 1'b0;
    byte_d    = 1'b0;
    if (enable) begin
      if (toggle) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
        pos_d  = ~sclk_q;
        neg_d  = sclk_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (pos_d) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_d    = (bit_cnt_q == 3'd7);
    end
  end

  // State registers; reset abandons any partial half-period or byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      sclk_q    <= 1'b0;
      pos_q     <= 1'b0;
      neg_q     <= 1'b0;
      byte_q    <= 1'b0;
      bit_cnt_q <= 3'd0;
    end else begin
      cnt_q     <= cnt_d;
      sclk_q    <= sclk_d;
      pos_q     <= pos_d;
      neg_q     <= neg_d;
      byte_q    <= byte_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sclk         = sclk_q;
  assign sclkPosEdge  = pos_q;
  assign sclkNegEdge  = neg_q;
  assign sclk8PosEdge = byte_q;
  assign bitCount     = bit_cnt_q;

endmodule

// File: tb/tb_serial_clock.sv
// tb_serial_clock: three serial_clock instances (HALF_PERIOD 2, 1, 3) share
// clk/reset/enable; a reference model derives every output from the number of
// enabled clk edges since the last reset.
module tb_serial_clock;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       sclk_w [3];
  logic       pos_w  [3];
  logic       neg_w  [3];
  logic       byte_w [3];
  logic [2:0] bc_w   [3];

  int n_cmp = 0;
  int n_bad = 0;
  int n_en = 0;       // enabled edges since reset
  bit en_last = 1'b0; // was the most recent edge an enabled one
  int cyc = 0;

  function automatic int hp_of(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 3;
  endfunction

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      serial_clock #(.HALF_PERIOD(hp_of(gi))) u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sclk        (sclk_w[gi]),
        .sclkPosEdge (pos_w[gi]),
        .sclkNegEdge (neg_w[gi]),
        .sclk8PosEdge(byte_w[gi]),
        .bitCount    (bc_w[gi])
      );
    end
  endgenerate

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model: after n enabled edges sclk has toggled n/HP times; rising edges are
  // the odd-numbered toggles; strobes only on an enabled edge completing a half.
  task automatic check_all(input string ctx);
    for (int i = 0; i < 3; i++) begin
      int  hp, t, e_bc;
      bit  at_tog, e_pos, e_neg, e_byte;
      hp     = hp_of(i);
      t      = n_en / hp;
      at_tog = en_last && (n_en > 0) && (n_en % hp == 0);
      e_pos  = at_tog && (t % 2 == 1);
      e_neg  = at_tog && (t % 2 == 0);
      e_bc   = ((t + 1) / 2) % 8;
      e_byte = e_pos && (e_bc == 0);
      check_val({ctx, "_sclk"}, 32'(sclk_w[i]), 32'(t % 2));
      check_val({ctx, "_pos"},  32'(pos_w[i]),  32'(e_pos));
      check_val({ctx, "_neg"},  32'(neg_w[i]),  32'(e_neg));
      check_val({ctx, "_bc"},   32'(bc_w[i]),   32'(e_bc));
      check_val({ctx, "_byte"}, 32'(byte_w[i]), 32'(e_byte));
      check_val({ctx, "_excl"}, 32'(pos_w[i] & neg_w[i]), 32'd0);
      check_val({ctx, "_b8imp"}, 32'(byte_w[i] & ~pos_w[i]), 32'd0);
    end
  endtask

  task automatic edge_step(input string ctx);
    @(posedge clk);
    cyc++;
    if (reset) begin
      if (enable) n_en++;
      en_last = enable;
    end
    #1;
    check_all(ctx);
    $display("cyc %0d %s rst=%0b en=%0b n=%0d sclk=%0b%0b%0b bc=%0d/%0d/%0d",
             cyc, ctx, reset, enable, n_en, sclk_w[0], sclk_w[1], sclk_w[2],
             bc_w[0], bc_w[1], bc_w[2]);
  endtask

  // Reset pulse placed between clk edges; outputs checked before any edge.
  task automatic async_reset(input string ctx);
    #1;
    reset = 1'b0;
    n_en = 0;
    en_last = 1'b0;
    #1;
    check_all(ctx);
    $display("cyc %0d %s async reset pulse", cyc, ctx);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [11:0] tab_sclk;
    logic [11:0] tab_pos;
    logic [11:0] tab_neg;
    tab_sclk = 12'b0110_0110_0110;
    tab_pos  = 12'b0010_0010_0010;
    tab_neg  = 12'b1000_1000_1000;

    // Reset held: state stays at zero even with enable high.
    #1;
    check_all("rst0");
    enable = 1'b1;
    repeat (3) edge_step("rsthold");
    #1;
    reset = 1'b1;

    // Free run from reset: fixed waveform for HALF_PERIOD=2, byte strobe at 30.
    for (int k = 1; k <= 40; k++) begin
      edge_step("run");
      if (k <= 12) begin
        check_val("hp2_sclk_tab", 32'(sclk_w[0]), 32'(tab_sclk[k-1]));
        check_val("hp2_pos_tab",  32'(pos_w[0]),  32'(tab_pos[k-1]));
        check_val("hp2_neg_tab",  32'(neg_w[0]),  32'(tab_neg[k-1]));
      end
      check_val("hp2_byte_at30", 32'(byte_w[0]), 32'(k == 30));
      if (k == 30) check_val("hp2_bc_wrap", 32'(bc_w[0]), 32'd0);
      if (k == 29) check_val("hp2_bc_pre",  32'(bc_w[0]), 32'd7);
    end

    // Freeze for 25 clks just after the 3rd rising edge (edge 10).
    async_reset("frz_rst");
    for (int k = 1; k <= 10; k++) edge_step("frz_pre");
    enable = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      edge_step("frz");
      check_val("frz_sclk", 32'(sclk_w[0]), 32'd1);
      check_val("frz_bc",   32'(bc_w[0]),   32'd3);
    end
    enable = 1'b1;
    for (int k = 36; k <= 40; k++) begin
      edge_step("frz_post");
      check_val("frz_next_pos", 32'(pos_w[0]), 32'(k == 39));
    end

    // HALF_PERIOD=3: abort while sclk=1, bitCount=5 (after 28 enabled edges).
    async_reset("ab_rst");
    for (int k = 1; k <= 28; k++) edge_step("ab_pre");
    check_val("hp3_sclk_pre", 32'(sclk_w[2]), 32'd1);
    check_val("hp3_bc_pre",   32'(bc_w[2]),   32'd5);
    async_reset("ab");
    check_val("hp3_sclk_ab", 32'(sclk_w[2]), 32'd0);
    check_val("hp3_bc_ab",   32'(bc_w[2]),   32'd0);
    for (int k = 1; k <= 3; k++) begin
      edge_step("ab_post");
      check_val("hp3_first_pos", 32'(pos_w[2]), 32'(k == 3));
    end

    // Random enable pattern with occasional asynchronous reset pulses.
    for (int k = 0; k < 300; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      edge_step("rnd");
      if ($urandom_range(0, 39) == 0) async_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
